// File: rtl/systolic_host_seq_if.sv
// systolic_host_seq_if
// External register-access bus of the systolic host controller.
//   ext_we / ext_addr / ext_wdata : write strobe, address and data
//   ext_re                        : read strobe
//   ext_rdata / ext_rvalid        : registered read response
// Handshake: the bus has no ready signal and never stalls. A write commits on
// the rising edge where ext_we=1. A read issued on the edge where ext_re=1
// returns ext_rvalid=1 with ext_rdata exactly one cycle later. ext_rvalid is
// 0 after any edge where ext_re was 0, and ext_rdata then keeps its last value.
// master = host side, slave = controller side.
interface systolic_host_seq_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          ext_we;
  logic          ext_re;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;

  modport master (
    output ext_we, ext_re, ext_addr, ext_wdata,
    input  ext_rdata, ext_rvalid
  );

  modport slave (
    input  ext_we, ext_re, ext_addr, ext_wdata,
    output ext_rdata, ext_rvalid
  );
endinterface

// File: rtl/systolic_host_seq.sv
// systolic_host_seq
// Host-side controller for an NxN systolic array. Holds the B weight matrix,
// the A left-edge vector and the captured result vector in one flat address
// space (B at 0..N*N-1, A next, then R, read-only) and runs a start-triggered
// CLEAR -> LOAD_B -> STREAM -> DRAIN -> CAPTURE sequence.
// Ports:
//   Clock, rst_n        : clock, asynchronous active-low reset
//   ext                 : register-access bus (slave side)
//   start               : begin a sequence, sampled only in IDLE
//   busy, done          : sequence in progress / results-captured pulse
//   wr_err              : sticky, A/B write attempted while busy
//   data_clear, en_shift_right, en_shift_bottom : array control
//   a_left_out, b_top_out, ps_top_out           : array inputs
//   ps_bottom_in        : array bottom-edge partial sums
//   state_dbg           : current FSM state encoding
module systolic_host_seq #(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                Clock,
  input  logic                rst_n,
  systolic_host_seq_if.slave  ext,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                wr_err,
  output logic                data_clear,
  output logic                en_shift_right,
  output logic                en_shift_bottom,
  output logic [N*DW-1:0]     a_left_out,
  output logic [N*DW-1:0]     b_top_out,
  output logic [N*DW-1:0]     ps_top_out,
  input  logic [N*DW-1:0]     ps_bottom_in,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD_B  = 3'd2,
    S_STREAM  = 3'd3,
    S_DRAIN   = 3'd4,
    S_CAPTURE = 3'd5
  } state_t;

  // Phase counter only needs to reach the longest phase length minus one.
  localparam int CMAX = (N > DRAIN_CYC) ? N : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX);

  localparam int unsigned B_END = N * N;
  localparam int unsigned A_END = N * N + N;
  localparam int unsigned R_END = N * N + 2 * N;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;

  logic [DW-1:0] b_mem [N*N];
  logic [DW-1:0] a_mem [N];
  logic [DW-1:0] r_mem [N];

  logic [31:0]   addr32;
  logic          hit_b, hit_a, hit_r;
  logic          ab_wr, wr_ok;
  logic [DW-1:0] rd_mux;

  assign addr32 = 32'(ext.ext_addr);
  assign hit_b  = (addr32 < B_END);
  assign hit_a  = (addr32 >= B_END) && (addr32 < A_END);
  assign hit_r  = (addr32 >= A_END) && (addr32 < R_END);
  assign ab_wr  = ext.ext_we && (hit_a || hit_b);
  assign wr_ok  = ab_wr && (state == S_IDLE);

  assign busy       = (state != S_IDLE);
  assign ps_top_out = '0;
  assign state_dbg  = state;

  // State register and phase counter; the counter restarts on every state change.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (state != S_IDLE) cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nx        = state;
    data_clear      = 1'b0;
    en_shift_right  = 1'b0;
    en_shift_bottom = 1'b0;
    done            = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = S_CLEAR;
      S_CLEAR: begin
        data_clear = 1'b1;
        state_nx   = S_LOAD_B;
      end
      S_LOAD_B: begin
        en_shift_bottom = 1'b1;
        if (cnt == CW'(N - 1)) state_nx = S_STREAM;
      end
      S_STREAM: begin
        en_shift_right = 1'b1;
        if (cnt == CW'(N - 1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        en_shift_bottom = 1'b1;
        if (cnt == CW'(DRAIN_CYC - 1)) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // Register file, result capture and the sticky write-error flag.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N * N; i++) b_mem[i] <= '0;
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= '0;
        r_mem[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      for (int i = 0; i < N * N; i++)
        if (wr_ok && (addr32 == 32'(i))) b_mem[i] <= ext.ext_wdata;
      for (int i = 0; i < N; i++)
        if (wr_ok && (addr32 == 32'(N * N + i))) a_mem[i] <= ext.ext_wdata;
      if (state == S_CAPTURE)
        for (int j = 0; j < N; j++) r_mem[j] <= ps_bottom_in[j*DW +: DW];
      // A rejected write can only occur outside IDLE, so it never collides
      // with the clear from an accepted start.
      if (ab_wr && (state != S_IDLE)) wr_err <= 1'b1;
      else if ((state == S_IDLE) && start) wr_err <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (hit_b) begin
      for (int i = 0; i < N * N; i++)
        if (addr32 == 32'(i)) rd_mux = b_mem[i];
    end else if (hit_a) begin
      for (int i = 0; i < N; i++)
        if (addr32 == 32'(N * N + i)) rd_mux = a_mem[i];
    end else if (hit_r) begin
      for (int i = 0; i < N; i++)
        if (addr32 == 32'(N * N + N + i)) rd_mux = r_mem[i];
    end
  end

  // Read port samples the pre-write contents, so a same-cycle read and write
  // of one address returns the old value.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      ext.ext_rdata  <= '0;
      ext.ext_rvalid <= 1'b0;
    end else begin
      ext.ext_rvalid <= ext.ext_re;
      if (ext.ext_re) ext.ext_rdata <= rd_mux;
    end
  end

  always_comb begin
    a_left_out = '0;
    for (int i = 0; i < N; i++) a_left_out[i*DW +: DW] = a_mem[i];
  end

  // Rows are fed bottom-up: phase step k presents row N-1-k.
  always_comb begin
    b_top_out = '0;
    if (state == S_LOAD_B) begin
      for (int r = 0; r < N; r++)
        if (cnt == CW'(N - 1 - r))
          for (int c = 0; c < N; c++) b_top_out[c*DW +: DW] = b_mem[r*N + c];
    end
  end

endmodule
